// File: rtl/ram8_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram8_arbiter_pkg
// Description : Shared definitions for the RAM8 two-port arbiter: FSM state
//               encoding, clear-sequence terminal count, last-served codes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ram8_arbiter_pkg;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Last address written by the post-reset clear sequence.
    localparam logic [2:0] INIT_LAST = 3'd7;

    // Encoding of the last-served register: 1 means requester B.
    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin tie-break. A lone requester always wins;
//               on a tie the requester that was not served last wins.
// Ports       : a_req, b_req  - request inputs
//               last_served   - 1 = B was served last, 0 = A
//               grant_a/b     - one-hot (or zero) grant outputs
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic a_req,
    input  logic b_req,
    input  logic last_served,
    output logic grant_a,
    output logic grant_b
);

    assign grant_a = a_req & (~b_req |  last_served);
    assign grant_b = b_req & (~a_req | ~last_served);

endmodule
`default_nettype wire

// File: rtl/ram8_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram8_arbiter
// Description : Arbitrates two requesters onto a single external RAM8 port.
//               After reset the RAM is cleared (8 writes of zero), then each
//               granted request takes IDLE -> ACCESS -> DONE (3 cycles).
// Ports       : clk, reset          - clock, async active-high reset
//               a_* / b_*           - requester A / B request and response
//               ram_addr/in/write   - shared RAM8 port drive
//               ram_out             - RAM8 combinational read data
//               busy                - high during the post-reset clear
// Revision    : 1.0 - initial release
// ============================================================================
module ram8_arbiter
    import ram8_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_write,
    input  logic [2:0]  a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_write,
    input  logic [2:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    output logic [2:0]  ram_addr,
    output logic [15:0] ram_in,
    output logic        ram_write,
    input  logic [15:0] ram_out,
    output logic        busy
);

    state_t      r_state;
    logic [2:0]  r_count;
    logic        r_last_b;
    logic        r_lat_b;
    logic        r_lat_write;
    logic [2:0]  r_lat_addr;
    logic [15:0] r_lat_wdata;

    logic        w_grant_a;
    logic        w_grant_b;

    rr_pick2 u_pick (
        .a_req       (a_req),
        .b_req       (b_req),
        .last_served (r_last_b),
        .grant_a     (w_grant_a),
        .grant_b     (w_grant_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_count     <= 3'd0;
            r_last_b    <= LAST_B;
            r_lat_b     <= 1'b0;
            r_lat_write <= 1'b0;
            r_lat_addr  <= 3'd0;
            r_lat_wdata <= 16'd0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rdata     <= 16'd0;
            b_rdata     <= 16'd0;
        end else begin
            case (r_state)
                S_INIT: begin
                    // Stop on the terminal count rather than wrapping, so the
                    // clear never revisits address 0.
                    if (r_count == INIT_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count + 3'd1;
                    end
                end
                S_IDLE: begin
                    if (w_grant_a || w_grant_b) begin
                        r_lat_b     <= w_grant_b;
                        r_lat_write <= w_grant_b ? b_write : a_write;
                        r_lat_addr  <= w_grant_b ? b_addr  : a_addr;
                        r_lat_wdata <= w_grant_b ? b_wdata : a_wdata;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Writes echo their own data back as the response.
                    if (r_lat_b) begin
                        b_rdata <= r_lat_write ? r_lat_wdata : ram_out;
                        b_ack   <= 1'b1;
                    end else begin
                        a_rdata <= r_lat_write ? r_lat_wdata : ram_out;
                        a_ack   <= 1'b1;
                    end
                    r_last_b <= r_lat_b;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    a_ack   <= 1'b0;
                    b_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    // RAM port decode from registered state. The clear-write strobe is gated
    // by reset so the port is quiet while reset is held.
    always_comb begin
        ram_write = 1'b0;
        ram_addr  = 3'd0;
        ram_in    = 16'd0;
        case (r_state)
            S_INIT: begin
                ram_write = ~reset;
                ram_addr  = r_count;
            end
            S_ACCESS: begin
                ram_write = r_lat_write;
                ram_addr  = r_lat_addr;
                ram_in    = r_lat_wdata;
            end
            default: begin
                ram_write = 1'b0;
            end
        endcase
    end

    assign busy = (r_state == S_INIT);

endmodule
`default_nettype wire
